// File: rtl/pcie_rcv.sv
// Receive side of the PCIe transaction path: two lane FIFOs with pause backpressure,
// a round-robin merge into one registered valid/ready output, and a link-status FSM.
// Define DEST_CHECK_EN to treat a word whose destination bit disagrees with its lane as a fault.
module pcie_rcv #(
   parameter int DW    = 6,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init,
   input  logic [AW-1:0] umbral_D0,
   input  logic [AW-1:0] umbral_D1,
   input  logic [DW-1:0] data_in0,
   input  logic          valid_in0,
   input  logic [DW-1:0] data_in1,
   input  logic          valid_in1,
   output logic          pausa_D0,
   output logic          pausa_D1,
   output logic [DW-1:0] data_out,
   output logic          valid_out,
   input  logic          ready_in,
   output logic [7:0]    rx_count0,
   output logic [7:0]    rx_count1,
   output logic          idle_out,
   output logic          active_out,
   output logic          error_out,
   output logic [1:0]    error_id
);

   localparam logic [2:0] ST_RESET  = 3'd0;
   localparam logic [2:0] ST_INIT   = 3'd1;
   localparam logic [2:0] ST_IDLE   = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;
   localparam logic [2:0] ST_ERROR  = 3'd4;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [2:0]    state, state_nxt;
   logic [DW-1:0] mem0 [DEPTH];
   logic [DW-1:0] mem1 [DEPTH];
   logic [AW-1:0] wr0, rd0, wr1, rd1;
   logic [AW:0]   cnt0, cnt1;
   logic [AW-1:0] umbral_reg0, umbral_reg1;
   logic          last_served;
   logic          run, slot_free, ne0, ne1, full0, full1;
   logic          pop0, pop1, room0, room1, bad0, bad1;
   logic          push0, push1, fault0, fault1;

   assign run       = (state == ST_IDLE) || (state == ST_ACTIVE);
   assign slot_free = !valid_out || ready_in;
   assign ne0       = (cnt0 != '0);
   assign ne1       = (cnt1 != '0);
   assign full0     = (cnt0 == CNT_FULL);
   assign full1     = (cnt1 == CNT_FULL);

   // Pops look only at registered counts, so a word needs one cycle in the FIFO before leaving.
   assign pop0  = run && slot_free && ne0 && (!ne1 || last_served);
   assign pop1  = run && slot_free && ne1 && (!ne0 || !last_served);
   assign room0 = !full0 || pop0;
   assign room1 = !full1 || pop1;

`ifdef DEST_CHECK_EN
   assign bad0 = (data_in0[4] != 1'b0);
   assign bad1 = (data_in1[4] != 1'b1);
`else
   assign bad0 = 1'b0;
   assign bad1 = 1'b0;
`endif

   assign push0  = run && valid_in0 && room0 && !bad0;
   assign push1  = run && valid_in1 && room1 && !bad1;
   assign fault0 = run && valid_in0 && (!room0 || bad0);
   assign fault1 = run && valid_in1 && (!room1 || bad1);

   assign pausa_D0   = (umbral_reg0 != '0) && (cnt0 >= {1'b0, umbral_reg0});
   assign pausa_D1   = (umbral_reg1 != '0) && (cnt1 >= {1'b0, umbral_reg1});
   assign idle_out   = (state == ST_IDLE);
   assign active_out = (state == ST_ACTIVE);
   assign error_out  = (state == ST_ERROR);

   // Next-state logic; a fault outranks init, and ERROR only leaves through reset.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RESET: state_nxt = ST_INIT;
         ST_INIT: begin
            if (!init) state_nxt = ST_IDLE;
            else       state_nxt = ST_INIT;
         end
         ST_IDLE, ST_ACTIVE: begin
            if (fault0 || fault1)              state_nxt = ST_ERROR;
            else if (init)                     state_nxt = ST_INIT;
            else if (ne0 || ne1 || valid_out)  state_nxt = ST_ACTIVE;
            else                               state_nxt = ST_IDLE;
         end
         ST_ERROR: state_nxt = ST_ERROR;
         default:  state_nxt = ST_RESET;
      endcase
   end

   // Lane storage; contents need no reset because counts gate every read.
   always_ff @(posedge clk) begin
      if (push0) mem0[wr0] <= data_in0;
      if (push1) mem1[wr1] <= data_in1;
   end

   // State, FIFO bookkeeping, thresholds, counters and the registered output slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_RESET;
         wr0         <= '0;
         rd0         <= '0;
         wr1         <= '0;
         rd1         <= '0;
         cnt0        <= '0;
         cnt1        <= '0;
         umbral_reg0 <= AW'(DEPTH - 1);
         umbral_reg1 <= AW'(DEPTH - 1);
         last_served <= 1'b1;
         data_out    <= '0;
         valid_out   <= 1'b0;
         rx_count0   <= 8'd0;
         rx_count1   <= 8'd0;
         error_id    <= 2'b00;
      end else begin
         state    <= state_nxt;
         error_id <= error_id | {fault1, fault0};
         if (state == ST_INIT) begin
            umbral_reg0 <= umbral_D0;
            umbral_reg1 <= umbral_D1;
         end
         if (push0) begin
            wr0       <= wr0 + AW'(1);
            rx_count0 <= rx_count0 + 8'd1;
         end
         if (push1) begin
            wr1       <= wr1 + AW'(1);
            rx_count1 <= rx_count1 + 8'd1;
         end
         cnt0 <= cnt0 + (AW+1)'(push0) - (AW+1)'(pop0);
         cnt1 <= cnt1 + (AW+1)'(push1) - (AW+1)'(pop1);
         if (pop0) begin
            data_out    <= mem0[rd0];
            valid_out   <= 1'b1;
            rd0         <= rd0 + AW'(1);
            last_served <= 1'b0;
         end else if (pop1) begin
            data_out    <= mem1[rd1];
            valid_out   <= 1'b1;
            rd1         <= rd1 + AW'(1);
            last_served <= 1'b1;
         end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule
